// File: rtl/mc_datapath_if.sv
// Unified instruction/data memory port: req/ready handshake with wait-state support.
interface mc_datapath_if #(
  parameter int unsigned WIDTH = 32
);
  logic             mem_req_o;
  logic             mem_we_o;
  logic [WIDTH-1:0] mem_addr_o;
  logic [WIDTH-1:0] mem_wdata_o;
  logic [WIDTH-1:0] mem_rdata_i;
  logic             mem_ready_i;

  // Core side of the port
  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ready_i
  );

  // Memory side of the port
  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ready_i
  );
endinterface

// File: rtl/mc_datapath.sv
// Multicycle MIPS-subset core slice: datapath registers, register file, ALU and the
// control sequencer, sharing one memory port that may insert wait states.
module mc_datapath #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      REG_WIDTH = 5,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic          clk,
  input  logic          rst,
  mc_datapath_if.master mem_bus,
  output logic          halt_o,
  output logic [31:0]   instret_o
);
  localparam int unsigned NumRegs = 2 ** REG_WIDTH;

  localparam logic [5:0] OpRType = 6'h00, OpLw = 6'h23, OpSw = 6'h2B;
  localparam logic [5:0] OpAddi = 6'h08, OpBeq = 6'h04, OpJ = 6'h02;
  localparam logic [5:0] FnAdd = 6'h20, FnSub = 6'h22, FnAnd = 6'h24;
  localparam logic [5:0] FnOr = 6'h25, FnSlt = 6'h2A;

  typedef enum logic [3:0] {
    StBoot, StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
    StRex, StRwb, StIex, StIwb, StBeq, StJmp, StHalt
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [WIDTH-1:0] mdr_q, mdr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic [31:0]      instret_q, instret_d;
  logic [WIDTH-1:0] rf_q [NumRegs];
  logic [WIDTH-1:0] rf_d [NumRegs];

  // Instruction fields; 5-bit register fields are resized to REG_WIDTH so that
  // out-of-range indices alias modulo the register file size.
  logic [5:0]           opcode, funct;
  logic [REG_WIDTH-1:0] rs_idx, rt_idx, rd_idx;
  logic [WIDTH-1:0]     imm_sext;
  logic [25:0]          target;

  assign opcode   = ir_q[31:26];
  assign funct    = ir_q[5:0];
  assign rs_idx   = REG_WIDTH'(ir_q[25:21]);
  assign rt_idx   = REG_WIDTH'(ir_q[20:16]);
  assign rd_idx   = REG_WIDTH'(ir_q[15:11]);
  assign imm_sext = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
  assign target   = ir_q[25:0];

  logic [WIDTH-1:0] alu_res;
  logic             funct_ok;

  // R-type ALU and recognition of the supported funct codes
  always_comb begin
    alu_res  = '0;
    funct_ok = 1'b1;
    case (funct)
      FnAdd:   alu_res = a_q + b_q;
      FnSub:   alu_res = a_q - b_q;
      FnAnd:   alu_res = a_q & b_q;
      FnOr:    alu_res = a_q | b_q;
      FnSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: funct_ok = 1'b0;
    endcase
  end

  logic                 rf_we;
  logic [REG_WIDTH-1:0] rf_waddr;
  logic [WIDTH-1:0]     rf_wdata;
  logic                 retire;

  // Sequencer: next state, datapath register updates and memory port drive
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mdr_d     = mdr_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    rf_we     = 1'b0;
    rf_waddr  = rt_idx;
    rf_wdata  = alu_out_q;
    retire    = 1'b0;
    halt_o    = 1'b0;
    mem_bus.mem_req_o   = 1'b0;
    mem_bus.mem_we_o    = 1'b0;
    mem_bus.mem_addr_o  = pc_q;
    mem_bus.mem_wdata_o = '0;

    unique case (state_q)
      StBoot: state_d = StFetch;
      StFetch: begin
        mem_bus.mem_req_o = 1'b1;
        if (mem_bus.mem_ready_i) begin
          ir_d    = mem_bus.mem_rdata_i[31:0];
          pc_d    = pc_q + WIDTH'(4);
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d       = rf_q[rs_idx];
        b_d       = rf_q[rt_idx];
        // Branch target computed speculatively; PC already points past the branch
        alu_out_d = pc_q + (imm_sext << 2);
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRType:    state_d = funct_ok ? StRex : StHalt;
          OpAddi:     state_d = StIex;
          OpBeq:      state_d = StBeq;
          OpJ:        state_d = StJmp;
          default:    state_d = StHalt;
        endcase
      end
      StMemAdr: begin
        alu_out_d = a_q + imm_sext;
        state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_bus.mem_req_o  = 1'b1;
        mem_bus.mem_addr_o = alu_out_q;
        if (mem_bus.mem_ready_i) begin
          mdr_d   = mem_bus.mem_rdata_i;
          state_d = StMemWb;
        end
      end
      StMemWb: begin
        rf_we    = 1'b1;
        rf_wdata = mdr_q;
        retire   = 1'b1;
        state_d  = StFetch;
      end
      StMemWr: begin
        mem_bus.mem_req_o   = 1'b1;
        mem_bus.mem_we_o    = 1'b1;
        mem_bus.mem_addr_o  = alu_out_q;
        mem_bus.mem_wdata_o = b_q;
        if (mem_bus.mem_ready_i) begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StRex: begin
        alu_out_d = alu_res;
        state_d   = StRwb;
      end
      StRwb: begin
        rf_we    = 1'b1;
        rf_waddr = rd_idx;
        retire   = 1'b1;
        state_d  = StFetch;
      end
      StIex: begin
        alu_out_d = a_q + imm_sext;
        state_d   = StIwb;
      end
      StIwb: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StBeq: begin
        if (a_q == b_q) pc_d = alu_out_q;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StJmp: begin
        pc_d    = {pc_q[WIDTH-1:28], target, 2'b00};
        retire  = 1'b1;
        state_d = StFetch;
      end
      StHalt:  halt_o = 1'b1;
      default: state_d = StHalt;
    endcase

    instret_d = retire ? instret_q + 32'd1 : instret_q;
  end

  // Register file write port; entry 0 is never written so it always reads zero
  always_comb begin
    rf_d = rf_q;
    if (rf_we && (rf_waddr != '0)) rf_d[rf_waddr] = rf_wdata;
  end

  assign instret_o = instret_q;

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StBoot;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      mdr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      instret_q <= '0;
      rf_q      <= '{default: '0};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mdr_q     <= mdr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      instret_q <= instret_d;
      rf_q      <= rf_d;
    end
  end
endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: a 32-bit core with a wait-state memory model and a
// 64-bit/16-register core with a zero-wait memory.
module tb_mc_datapath;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst64;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rel_cyc;

  always @(posedge clk) cyc = cyc + 1;

  // 32-bit core, RESET_PC = 0x100
  mc_datapath_if #(.WIDTH(32)) bus ();
  logic        halt;
  logic [31:0] instret;

  mc_datapath #(.WIDTH(32), .REG_WIDTH(5), .RESET_PC(32'h100)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_bus   (bus),
    .halt_o    (halt),
    .instret_o (instret)
  );

  // 64-bit core with a 16-entry register file
  mc_datapath_if #(.WIDTH(64)) bus64 ();
  logic        halt64;
  logic [31:0] instret64;

  mc_datapath #(.WIDTH(64), .REG_WIDTH(4), .RESET_PC(64'h0)) dut64 (
    .clk       (clk),
    .rst       (rst64),
    .mem_bus   (bus64),
    .halt_o    (halt64),
    .instret_o (instret64)
  );

  // Memory model for the 32-bit core with a programmable number of wait states
  logic [31:0] mem [256];
  int          wait_cycles = 0;
  int          wcnt = 0;
  logic        idle_ready = 1'b1;
  logic [31:0] acc_addr [64];
  logic        acc_we [64];
  logic [31:0] acc_wdata [64];
  int          acc_cyc [64];
  int          n_acc = 0;
  int          unstable = 0;
  logic        in_acc = 1'b0;
  logic [31:0] p_addr, p_wdata;
  logic        p_we;

  always @(negedge clk) begin
    if (bus.mem_req_o) begin
      if (in_acc && (bus.mem_addr_o !== p_addr || bus.mem_we_o !== p_we ||
                     bus.mem_wdata_o !== p_wdata))
        unstable = unstable + 1;
      in_acc  = 1'b1;
      p_addr  = bus.mem_addr_o;
      p_we    = bus.mem_we_o;
      p_wdata = bus.mem_wdata_o;
      bus.mem_rdata_i = mem[bus.mem_addr_o[9:2]];
      if (wcnt >= wait_cycles) begin
        bus.mem_ready_i = 1'b1;
        wcnt   = 0;
        in_acc = 1'b0;
        if (n_acc < 64) begin
          acc_addr[n_acc]  = bus.mem_addr_o;
          acc_we[n_acc]    = bus.mem_we_o;
          acc_wdata[n_acc] = bus.mem_wdata_o;
          acc_cyc[n_acc]   = cyc;
          n_acc = n_acc + 1;
        end
        if (bus.mem_we_o) mem[bus.mem_addr_o[9:2]] = bus.mem_wdata_o;
      end else begin
        bus.mem_ready_i = 1'b0;
        wcnt = wcnt + 1;
      end
    end else begin
      bus.mem_ready_i = idle_ready;
      bus.mem_rdata_i = '0;
      wcnt   = 0;
      in_acc = 1'b0;
    end
  end

  // Zero-wait memory for the 64-bit core; stores are only logged
  logic [31:0] mem64 [16];
  logic [63:0] st64_addr = '0;
  logic [63:0] st64_data = '0;
  int          st64_n = 0;

  always @(negedge clk) begin
    bus64.mem_ready_i = 1'b1;
    bus64.mem_rdata_i = {32'h0, mem64[bus64.mem_addr_o[5:2]]};
    if (bus64.mem_req_o && bus64.mem_we_o) begin
      st64_addr = bus64.mem_addr_o;
      st64_data = bus64.mem_wdata_o;
      st64_n    = st64_n + 1;
    end
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    n_acc    = 0;
    unstable = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    rst     = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic run_to_halt(input int budget);
    for (int i = 0; i < budget && !halt; i++) @(posedge clk);
    #1;
  endtask

  int exp_lat [9];
  logic [31:0] exp_pc [10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst   = 1'b0;
    rst64 = 1'b0;
    bus.mem_ready_i   = 1'b0;
    bus.mem_rdata_i   = '0;
    bus64.mem_ready_i = 1'b0;
    bus64.mem_rdata_i = '0;

    // 64-bit core: sign extension to 64 bits and register-field aliasing (17 -> r1)
    for (int i = 0; i < 16; i++) mem64[i] = 32'h0;
    mem64[0] = enc_i(6'h08, 5'd0, 5'd1, 16'hFFFF);
    mem64[1] = enc_i(6'h2B, 5'd0, 5'd17, 16'h0010);
    mem64[2] = enc_i(6'h08, 5'd17, 5'd18, 16'hFFFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst64 = 1'b1;
    for (int i = 0; i < 60 && !halt64; i++) @(posedge clk);
    #1;
    check("w64_halt", {63'h0, halt64}, 64'd1);
    check("w64_r1", dut64.rf_q[1], 64'hFFFF_FFFF_FFFF_FFFF);
    check("w64_r2_alias", dut64.rf_q[2], 64'hFFFF_FFFF_FFFF_FFFE);
    check("w64_store_n", 64'(st64_n), 64'd1);
    check("w64_store_addr", st64_addr, 64'h10);
    check("w64_store_data", st64_data, 64'hFFFF_FFFF_FFFF_FFFF);
    check("w64_instret", {32'h0, instret64}, 64'd3);

    // Reset state, then addi followed by an illegal opcode
    hold_reset();
    mem[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[65] = 32'hFC00_0000;
    #1;
    check("rst_req", {63'h0, bus.mem_req_o}, 64'd0);
    check("rst_we", {63'h0, bus.mem_we_o}, 64'd0);
    check("rst_addr", {32'h0, bus.mem_addr_o}, 64'h100);
    check("rst_wdata", {32'h0, bus.mem_wdata_o}, 64'd0);
    check("rst_halt", {63'h0, halt}, 64'd0);
    check("rst_instret", {32'h0, instret}, 64'd0);
    release_reset();
    run_to_halt(50);
    check("p1_halt", {63'h0, halt}, 64'd1);
    check("p1_first_addr", {32'h0, acc_addr[0]}, 64'h100);
    check("p1_boot_cycle", 64'(acc_cyc[0] - rel_cyc), 64'd1);
    check("p1_second_addr", {32'h0, acc_addr[1]}, 64'h104);
    check("p1_r1", {32'h0, dut.rf_q[1]}, 64'd5);
    check("p1_instret", {32'h0, instret}, 64'd1);
    repeat (10) @(posedge clk);
    #1;
    check("p1_no_more_req", 64'(n_acc), 64'd2);
    check("p1_req_low", {63'h0, bus.mem_req_o}, 64'd0);

    // R-type ALU with r2 = -3, r3 = 2; a write to r0; an unsupported funct halts
    hold_reset();
    mem[64] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    mem[65] = enc_i(6'h08, 5'd0, 5'd3, 16'd2);
    mem[66] = enc_r(5'd2, 5'd3, 5'd4, 6'h20);
    mem[67] = enc_r(5'd2, 5'd3, 5'd5, 6'h22);
    mem[68] = enc_r(5'd2, 5'd3, 5'd6, 6'h2A);
    mem[69] = enc_r(5'd2, 5'd3, 5'd0, 6'h20);
    mem[70] = enc_r(5'd2, 5'd3, 5'd8, 6'h24);
    mem[71] = enc_r(5'd2, 5'd3, 5'd9, 6'h25);
    release_reset();
    run_to_halt(100);
    check("p2_halt", {63'h0, halt}, 64'd1);
    check("p2_add", {32'h0, dut.rf_q[4]}, 64'hFFFF_FFFF);
    check("p2_sub", {32'h0, dut.rf_q[5]}, 64'hFFFF_FFFB);
    check("p2_slt", {32'h0, dut.rf_q[6]}, 64'd1);
    check("p2_r0", {32'h0, dut.rf_q[0]}, 64'd0);
    check("p2_and", {32'h0, dut.rf_q[8]}, 64'd0);
    check("p2_or", {32'h0, dut.rf_q[9]}, 64'hFFFF_FFFF);
    check("p2_instret", {32'h0, instret}, 64'd8);
    check("p2_n_acc", 64'(n_acc), 64'd9);
    for (int k = 0; k < 8; k++) check("p2_latency", 64'(acc_cyc[k+1] - acc_cyc[k]), 64'd4);

    // Store then load with three wait states on every access
    hold_reset();
    wait_cycles = 3;
    mem[64] = enc_i(6'h08, 5'd0, 5'd3, 16'd2);
    mem[65] = enc_i(6'h2B, 5'd0, 5'd3, 16'd8);
    mem[66] = enc_i(6'h23, 5'd0, 5'd7, 16'd8);
    release_reset();
    run_to_halt(200);
    check("p3_halt", {63'h0, halt}, 64'd1);
    check("p3_n_acc", 64'(n_acc), 64'd6);
    check("p3_st_we", {63'h0, acc_we[2]}, 64'd1);
    check("p3_st_addr", {32'h0, acc_addr[2]}, 64'd8);
    check("p3_st_data", {32'h0, acc_wdata[2]}, 64'd2);
    check("p3_ld_we", {63'h0, acc_we[4]}, 64'd0);
    check("p3_ld_addr", {32'h0, acc_addr[4]}, 64'd8);
    check("p3_r7", {32'h0, dut.rf_q[7]}, 64'd2);
    check("p3_mem", {32'h0, mem[2]}, 64'd2);
    check("p3_addi_lat", 64'(acc_cyc[1] - acc_cyc[0]), 64'd7);
    check("p3_sw_lat", 64'(acc_cyc[3] - acc_cyc[1]), 64'd10);
    check("p3_lw_lat", 64'(acc_cyc[5] - acc_cyc[3]), 64'd11);
    check("p3_stable", 64'(unstable), 64'd0);
    wait_cycles = 0;

    // Branches and jumps: beq taken/not taken at 0x10, j 0x40 back to 0x100
    hold_reset();
    mem[64] = enc_i(6'h04, 5'd2, 5'd0, 16'd1);
    mem[66] = enc_i(6'h08, 5'd0, 5'd2, 16'd1);
    mem[67] = enc_j(26'h4);
    mem[4]  = enc_i(6'h04, 5'd0, 5'd1, 16'd3);
    mem[5]  = enc_j(26'h40);
    mem[8]  = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    mem[9]  = enc_j(26'h4);
    exp_pc  = '{32'h100, 32'h108, 32'h10C, 32'h10, 32'h20, 32'h24, 32'h10, 32'h14,
                32'h100, 32'h104};
    exp_lat = '{3, 4, 3, 3, 4, 3, 3, 3, 3};
    release_reset();
    run_to_halt(100);
    check("p4_halt", {63'h0, halt}, 64'd1);
    check("p4_n_acc", 64'(n_acc), 64'd10);
    check("p4_instret", {32'h0, instret}, 64'd9);
    for (int k = 0; k < 10; k++) check("p4_fetch_pc", {32'h0, acc_addr[k]}, {32'h0, exp_pc[k]});
    for (int k = 0; k < 9; k++)
      check("p4_latency", 64'(acc_cyc[k+1] - acc_cyc[k]), 64'(exp_lat[k]));

    // Reset asserted while a fetch waits on ready
    hold_reset();
    mem[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[65] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
    release_reset();
    for (int i = 0; i < 40 && instret != 32'd2; i++) begin
      @(posedge clk);
      #1;
    end
    wait_cycles = 1000;
    check("p5_instret", {32'h0, instret}, 64'd2);
    repeat (3) @(posedge clk);
    #1;
    check("p5_wait_req", {63'h0, bus.mem_req_o}, 64'd1);
    check("p5_wait_addr", {32'h0, bus.mem_addr_o}, 64'h108);
    #2;
    rst = 1'b0;
    #1;
    check("p5_req_drop", {63'h0, bus.mem_req_o}, 64'd0);
    check("p5_addr", {32'h0, bus.mem_addr_o}, 64'h100);
    check("p5_instret0", {32'h0, instret}, 64'd0);
    check("p5_r1", {32'h0, dut.rf_q[1]}, 64'd0);
    check("p5_r2", {32'h0, dut.rf_q[2]}, 64'd0);
    check("p5_abandoned", 64'(n_acc), 64'd2);
    wait_cycles = 0;
    n_acc = 0;
    release_reset();
    repeat (3) @(posedge clk);
    #1;
    check("p5_refetch_addr", {32'h0, acc_addr[0]}, 64'h100);
    check("p5_boot_cycle", 64'(acc_cyc[0] - rel_cyc), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
